// File: rtl/vga_text.sv
`timescale 1ns/1ps
// Text-mode pixel generator: character/attribute buffer, external font ROM lookup,
// blink attribute and blinking cursor, with a fixed 3-cycle raster-to-output latency.
module vga_text #(
   parameter int COLS = 80,
   parameter int ROWS = 30,
   parameter int XW   = 10,
   parameter int YW   = 10
) (
   input  logic          CLK,
   input  logic          RST_,
   input  logic          HB,
   input  logic          VB,
   input  logic          HS_,
   input  logic          VS_,
   input  logic [XW-1:0] X,
   input  logic [YW-1:0] Y,
   input  logic          WE,
   input  logic [11:0]   WADDR,
   input  logic [15:0]   WDATA,
   input  logic          CUR_EN,
   input  logic [6:0]    CUR_X,
   input  logic [4:0]    CUR_Y,
   output logic [11:0]   FADDR,
   input  logic [7:0]    FDATA,
   output logic [3:0]    R,
   output logic [3:0]    G,
   output logic [3:0]    B,
   output logic          HS_O,
   output logic          VS_O,
   output logic          DE
);
   localparam int          DEPTH   = COLS * ROWS;
   localparam int          CW      = XW - 3;
   localparam int          RW      = YW - 4;
   localparam logic [11:0] DEPTH_A = 12'(DEPTH);

   logic [15:0]   mem [DEPTH];
   logic [11:0]   rd_addr;
   logic [CW-1:0] col;
   logic [RW-1:0] row;

   assign col = X[XW-1:3];
   assign row = Y[YW-1:4];

   generate
      if (COLS == 80) begin : g_addr80
         assign rd_addr = (12'(row) << 6) + (12'(row) << 4) + 12'(col);
      end else begin : g_addr_mul
         assign rd_addr = 12'(row) * 12'(COLS) + 12'(col);
      end
   endgenerate

   // {I,R,G,B} palette; index 6 is dimmed to brown rather than dark yellow.
   function automatic logic [11:0] palette(input logic [3:0] idx);
      logic [3:0]  on_v;
      logic [3:0]  off_v;
      logic [11:0] c;
      on_v  = idx[3] ? 4'hF : 4'hA;
      off_v = idx[3] ? 4'h5 : 4'h0;
      c = {idx[2] ? on_v : off_v, idx[1] ? on_v : off_v, idx[0] ? on_v : off_v};
      if (idx == 4'd6) c[7:4] = 4'h5;
      return c;
   endfunction

   logic          blank_p0_q, blank_p0_d, blank_p1_q, blank_p1_d, blank_p2_q, blank_p2_d;
   logic          hs_p0_q, hs_p0_d, hs_p1_q, hs_p1_d, hs_p2_q, hs_p2_d;
   logic          vs_p0_q, vs_p0_d, vs_p1_q, vs_p1_d, vs_p2_q, vs_p2_d;
   logic          vb_q, vb_d;
   logic [5:0]    frame_q, frame_d;
   logic [11:0]   faddr_q, faddr_d;
   logic [11:0]   rgb_q, rgb_d;
   logic          hs_o_q, hs_o_d, vs_o_q, vs_o_d, de_q, de_d;

   logic [15:0]   ram_q;
   logic [2:0]    x_p0_q, x_p0_d, x_p1_q, x_p1_d, x_p2_q, x_p2_d;
   logic [3:0]    line_p0_q, line_p0_d, line_p1_q, line_p1_d, line_p2_q, line_p2_d;
   logic [CW-1:0] col_p0_q, col_p0_d;
   logic [RW-1:0] row_p0_q, row_p0_d;
   logic [7:0]    attr_p1_q, attr_p1_d, attr_p2_q, attr_p2_d;
   logic          cur_p1_q, cur_p1_d, cur_p2_q, cur_p2_d;

   logic          pix;
   logic [3:0]    cidx;

   always_comb begin
      // stage 0: raster sample, buffer read issued
      blank_p0_d = HB | VB;
      hs_p0_d    = HS_;
      vs_p0_d    = VS_;
      x_p0_d     = X[2:0];
      line_p0_d  = Y[3:0];
      col_p0_d   = col;
      row_p0_d   = row;
      vb_d       = VB;
      frame_d    = frame_q + 6'(VB & ~vb_q);

      // stage 1: cell word available, font address issued
      blank_p1_d = blank_p0_q;
      hs_p1_d    = hs_p0_q;
      vs_p1_d    = vs_p0_q;
      x_p1_d     = x_p0_q;
      line_p1_d  = line_p0_q;
      attr_p1_d  = ram_q[15:8];
      cur_p1_d   = (col_p0_q == CW'(CUR_X)) && (row_p0_q == RW'(CUR_Y));
      faddr_d    = {ram_q[7:0], line_p0_q};

      // stage 2: font byte available, pixel and colour resolved
      blank_p2_d = blank_p1_q;
      hs_p2_d    = hs_p1_q;
      vs_p2_d    = vs_p1_q;
      x_p2_d     = x_p1_q;
      line_p2_d  = line_p1_q;
      attr_p2_d  = attr_p1_q;
      cur_p2_d   = cur_p1_q;

      pix = FDATA[3'd7 - x_p2_q];
      if (attr_p2_q[7] && !frame_q[5]) pix = 1'b0;
      if (CUR_EN && frame_q[5] && cur_p2_q && (line_p2_q[3:1] == 3'b111)) pix = 1'b1;
      cidx = pix ? attr_p2_q[3:0] : {1'b0, attr_p2_q[6:4]};

      // stage 3: registered outputs
      rgb_d  = blank_p2_q ? 12'h000 : palette(cidx);
      de_d   = ~blank_p2_q;
      hs_o_d = hs_p2_q;
      vs_o_d = vs_p2_q;
   end

   always_ff @(posedge CLK or negedge RST_) begin
      if (!RST_) begin
         blank_p0_q <= 1'b1;
         blank_p1_q <= 1'b1;
         blank_p2_q <= 1'b1;
         hs_p0_q    <= 1'b1;
         hs_p1_q    <= 1'b1;
         hs_p2_q    <= 1'b1;
         vs_p0_q    <= 1'b1;
         vs_p1_q    <= 1'b1;
         vs_p2_q    <= 1'b1;
         vb_q       <= 1'b0;
         frame_q    <= 6'd0;
         faddr_q    <= 12'h000;
         rgb_q      <= 12'h000;
         hs_o_q     <= 1'b1;
         vs_o_q     <= 1'b1;
         de_q       <= 1'b0;
      end else begin
         blank_p0_q <= blank_p0_d;
         blank_p1_q <= blank_p1_d;
         blank_p2_q <= blank_p2_d;
         hs_p0_q    <= hs_p0_d;
         hs_p1_q    <= hs_p1_d;
         hs_p2_q    <= hs_p2_d;
         vs_p0_q    <= vs_p0_d;
         vs_p1_q    <= vs_p1_d;
         vs_p2_q    <= vs_p2_d;
         vb_q       <= vb_d;
         frame_q    <= frame_d;
         faddr_q    <= faddr_d;
         rgb_q      <= rgb_d;
         hs_o_q     <= hs_o_d;
         vs_o_q     <= vs_o_d;
         de_q       <= de_d;
      end
   end

   // Buffer and datapath carry no reset; read-before-write on address collision.
   always_ff @(posedge CLK) begin
      if (WE && (WADDR < DEPTH_A)) mem[WADDR] <= WDATA;
      ram_q     <= mem[rd_addr];
      x_p0_q    <= x_p0_d;
      x_p1_q    <= x_p1_d;
      x_p2_q    <= x_p2_d;
      line_p0_q <= line_p0_d;
      line_p1_q <= line_p1_d;
      line_p2_q <= line_p2_d;
      col_p0_q  <= col_p0_d;
      row_p0_q  <= row_p0_d;
      attr_p1_q <= attr_p1_d;
      attr_p2_q <= attr_p2_d;
      cur_p1_q  <= cur_p1_d;
      cur_p2_q  <= cur_p2_d;
   end

   assign FADDR = faddr_q;
   assign R     = rgb_q[11:8];
   assign G     = rgb_q[7:4];
   assign B     = rgb_q[3:0];
   assign HS_O  = hs_o_q;
   assign VS_O  = vs_o_q;
   assign DE    = de_q;

endmodule

// File: doc/vga_text.md
# vga_text

Text-mode pixel generator that sits directly downstream of the VGA timing generator. It consumes the raster position, blanking and sync strobes and looks up an 80×30 character/attribute buffer and an external 8×16 font ROM. It outputs 12-bit RGB with sync and data-enable delayed to match its fixed 3-cycle pipeline. It also provides a same-clock write port for the character buffer, a blinking hardware cursor and a per-cell blink attribute.

## Interface

Parameters:
- COLS, 80, text columns
- ROWS, 30, text rows
- XW, 10, width of X input
- YW, 10, width of Y input

Ports:
- CLK  in  1  pixel clock, same clock as the timing generator
- RST_  in  1  reset, asynchronous, active-low
- HB, VB  in  1  horizontal/vertical blanking from timing generator
- HS_, VS_  in  1  active-low syncs from timing generator
- X  in  XW  pixel column
- Y  in  YW  pixel line
- WE  in  1  character buffer write strobe
- WADDR  in  12  cell address = row*COLS + col
- WDATA  in  16  [7:0] char code, [11:8] fg index, [14:12] bg index, [15] blink
- CUR_EN  in  1  cursor enable
- CUR_X  in  7  cursor column
- CUR_Y  in  5  cursor row
- FADDR  out  12  font ROM address {char[7:0], line[3:0]}
- FDATA  in  8  font ROM data, synchronous, valid 1 cycle after FADDR; bit 7 is leftmost pixel
- R, G, B  out  4 each  pixel colour
- HS_O, VS_O  out  1  delayed syncs, active-low
- DE  out  1  delayed display enable = !(HB|VB)

## Operation

- Character buffer: COLS*ROWS × 16 inferred RAM, written on a CLK edge when WE is high. WADDR ≥ COLS*ROWS is ignored. A read and a write to the same address in the same cycle return the old data (read-first). The buffer is not reset and its contents are undefined after power-up.
- Cell address is computed as (Y>>4)*COLS + (X>>3), implemented as shift-add for COLS=80 ((r<<6)+(r<<4)+c). The address is don't-care while HB|VB.
- Frame counter: 6 bits, cleared by reset. It increments on each rising edge of VB, detected against a registered copy of VB. Its bit 5 is the blink phase P. The counter wraps 63→0.
- Pixel select:
  - bit = FDATA[7 − x[2:0]].
  - Blink cells: if attribute[15]=1 and P=0, bit is forced to 0.
  - Cursor: bit is forced to 1 when CUR_EN=1, P=1, the cell equals (CUR_X, CUR_Y), and the cell line is 14 or 15.
  - Colour index = bit ? fg : {1'b0, bg}.
- Palette, index i = {I,R,G,B}:
  - Each channel = bit ? (I ? F : A) : (I ? 5 : 0).
  - Exception: index 6 is G=5, giving R=A,G=5,B=0.
- When the delayed DE=0, R=G=B=0.

## Timing

- Stage 0 (edge n): RAM read issued from X,Y. The pipeline registers x[2:0], Y[3:0], cell (col,row), HB|VB, HS_ and VS_.
- Stage 1 (n+1): RAM data registered; FADDR is driven from registers, using char code and line.
- Stage 2 (n+2): FDATA valid; pixel and colour are computed.
- Stage 3 (n+3): R, G, B, HS_O, VS_O and DE are registered. Every output reflects inputs sampled at edge n, so latency is exactly 3 cycles for all outputs.
- Reset values (while RST_=0): R=G=B=0, HS_O=VS_O=1, DE=0, FADDR=0. All pipeline sync/blank registers are set to their inactive values and the frame counter is 0.
- Reset mid-frame: outputs are valid again 3 edges after RST_ rises. The buffer keeps its contents.
- Buffer writes become visible on the next raster pass over that cell. No write handshake exists; one write is accepted per cycle.

## Test plan

- Reset: hold RST_ low with toggling inputs → R=G=B=0, HS_O=VS_O=1, DE=0. After release, the first valid DE appears 3 edges after HB/VB both go low.
- Latency: HS_ falls at edge n → HS_O falls at n+3. The same holds for VS_ and for DE relative to HB.
- Glyph:
  - Stimulus: write addr 0 = 16'h1F41; the font model returns 8'h18 for 12'h410; run line Y=0.
  - FADDR = 12'h410 during X=0..7, delayed by 1.
  - Pixels X=3,4 → RGB FFF. Other X=0..7 → 00A.
- Bounds:
  - Write addr 2399 → appears at X=632..639, Y=464..479.
  - Write WADDR=2400 with WE=1 → addr 0 is unchanged.
  - During HB, RGB=000 regardless of buffer data.
- Cursor/blink:
  - Stimulus: CUR_EN=1, CUR_X=5, CUR_Y=2.
  - Frames 0–31: lines 46–47 at X=40..47 show the glyph only.
  - Frames 32–63: those lines show fg.
  - A cell with attribute bit 15 set shows bg only during frames 0–31.
- Read/write collision: write a cell in the same cycle its read is issued → old glyph is displayed this frame and the new glyph next frame.
